// File: rtl/cpu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Op and FSM state types plus a magnitude helper.
package cpu_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_RUN    = 2'b01,
        MD_FINISH = 2'b10
    } md_state_e;

    function automatic logic [MD_WIDTH-1:0] md_abs(
        input logic [MD_WIDTH-1:0] v,
        input logic                neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Command/result bundle between the execute controller
// and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    import cpu_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] writeData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operandA, operandB,
        output hiWrite, loWrite, writeData,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operandA, operandB,
        input  hiWrite, loWrite, writeData,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/md_iter_step.sv
// One iteration of shift-add multiply or restoring divide
// over a double-width {upper, lower} accumulator.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
             + (acc_i[0] ? {1'b0, opnd_i} : '0);
        diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
        acc_o = {sum, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            // Borrow out means the trial subtraction failed: restore.
            if (diff[WIDTH])
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            else
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Fixed 33-edge latency from start to HI/LO update.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_in;
    logic               sa_in;
    logic               sb_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               is_div_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign signed_in = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    assign sa_in     = signed_in & bus.operandA[WIDTH-1];
    assign sb_in     = signed_in & bus.operandB[WIDTH-1];
    assign a_mag     = md_abs(bus.operandA, sa_in);
    assign b_mag     = md_abs(bus.operandB, sb_in);
    assign is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_step)
    );

    // Divide by zero: quotient forced to all ones, remainder fixup
    // then reproduces operandA exactly.
    assign prod    = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo_fix = (opnd_q == '0) ? '1
                   : (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0]
                   : acc_q[WIDTH-1:0];
    assign rem_fix = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH]
                   : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    sign_a_d = sa_in;
                    sign_b_d = sb_in;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = MD_RUN;
                    if (bus.op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end else begin
                    if (bus.hiWrite) hi_d = bus.writeData;
                    if (bus.loWrite) lo_d = bus.writeData;
                end
            end
            MD_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = MD_FINISH;
            end
            MD_FINISH: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = MD_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency,
// HI/LO writes, interference and asynchronous reset.
module tb_mult_div_unit;
    import cpu_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic done_seen;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input md_op_e o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit wr, input bit intf);
        bus.start     = 1'b1;
        bus.op        = o;
        bus.operandA  = a;
        bus.operandB  = b;
        bus.hiWrite   = wr;
        bus.loWrite   = wr;
        bus.writeData = 32'hCAFEF00D;
        tick();
        bus.start    = 1'b0;
        bus.hiWrite  = 1'b0;
        bus.loWrite  = 1'b0;
        bus.op       = (o == MD_DIV) ? MD_MULTU : MD_DIV;
        bus.operandA = ~a;
        bus.operandB = ~b;
        check({tag, ":busy_e0"}, {31'b0, bus.busy}, 32'd1);
        for (int i = 1; i <= 32; i++) begin
            if (intf && i == 5) begin
                bus.start     = 1'b1;
                bus.op        = MD_MULTU;
                bus.operandA  = 32'd2;
                bus.operandB  = 32'd2;
                bus.loWrite   = 1'b1;
                bus.writeData = 32'h5555AAAA;
            end
            tick();
            bus.start   = 1'b0;
            bus.loWrite = 1'b0;
            if (i == 16) begin
                check({tag, ":hold_hi"}, bus.hi, exp_hi);
                check({tag, ":hold_lo"}, bus.lo, exp_lo);
            end
        end
        check({tag, ":busy_e32"}, {31'b0, bus.busy}, 32'd1);
        check({tag, ":done_e32"}, {31'b0, bus.done}, 32'd0);
        tick();
        check({tag, ":done_e33"}, {31'b0, bus.done}, 32'd1);
        check({tag, ":busy_e33"}, {31'b0, bus.busy}, 32'd0);
        check({tag, ":hi"}, bus.hi, eh);
        check({tag, ":lo"}, bus.lo, el);
        exp_hi = eh;
        exp_lo = el;
        tick();
        check({tag, ":done_e34"}, {31'b0, bus.done}, 32'd0);
        check({tag, ":busy_e34"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_chk         = 0;
        n_err         = 0;
        exp_hi        = '0;
        exp_lo        = '0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = MD_MULT;
        bus.operandA  = '0;
        bus.operandB  = '0;
        bus.hiWrite   = 1'b0;
        bus.loWrite   = 1'b0;
        bus.writeData = '0;
        tick();
        tick();
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;
        tick();

        bus.hiWrite   = 1'b1;
        bus.writeData = 32'hAAAA5555;
        tick();
        bus.hiWrite = 1'b0;
        check("mthi_hi", bus.hi, 32'hAAAA5555);
        check("mthi_lo", bus.lo, 32'd0);
        bus.hiWrite   = 1'b1;
        bus.loWrite   = 1'b1;
        bus.writeData = 32'h0F0F0F0F;
        tick();
        bus.hiWrite = 1'b0;
        bus.loWrite = 1'b0;
        check("mtboth_hi", bus.hi, 32'h0F0F0F0F);
        check("mtboth_lo", bus.lo, 32'h0F0F0F0F);
        exp_hi = 32'h0F0F0F0F;
        exp_lo = 32'h0F0F0F0F;

        run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
        run_op("mult_m3x7", MD_MULT, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op("mult_min2", MD_MULT, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 1'b0, 1'b0);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 1'b0);
        run_op("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'h00000010,
               32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0);
        run_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("div_by0", MD_DIV, 32'h12345678, 32'd0,
               32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_neg_by0", MD_DIV, 32'hFFFFFFFB, 32'd0,
               32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_min_m1", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 1'b0, 1'b0);
        run_op("multu_intf", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);

        bus.start    = 1'b1;
        bus.op       = MD_DIVU;
        bus.operandA = 32'd1000;
        bus.operandB = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        check("abort_busy_pre", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        done_seen = 1'b0;
        tick();
        done_seen = done_seen | bus.done;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            done_seen = done_seen | bus.done;
        end
        check("abort_no_done", {31'b0, done_seen}, 32'd0);
        check("abort_idle", {31'b0, bus.busy}, 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        run_op("multu_6x7", MD_MULTU, 32'd6, 32'd7,
               32'd0, 32'd42, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
